rtc_bus_arbiter: RTL and testbench
==================================

# rtc_bus_arbiter

Shares the single RTC read/write transaction engine among three requesters: the alarm-clear writer, the memory-sweep reader, and the user-edit writer. It selects one request at a time and forwards its address, data and direction to the engine. It then waits for the engine's completion strobe and returns a done pulse, read data and an error flag to the winner. It sits between the menu/alarm FSMs and the RTC bus controller and is the only block that drives the engine's start input.

## Interface
- TIMEOUT, 8'd200: cycles to wait for BUS_DONE after BUS_START before aborting; legal range 2..255.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- REQ  in  3  request level per requester; bit0 = alarm clear, bit1 = sweep read, bit2 = edit write.
- WR  in  3  per-requester direction; 1 = write, 0 = read.
- ADDR  in  21  packed 7-bit RTC addresses; [6:0] is req0, [13:7] is req1, [20:14] is req2.
- WDATA  in  24  packed 8-bit write data, same packing as ADDR.
- GNT  out  3  one-hot grant, held for the whole transaction.
- DONE_OUT  out  3  one-hot, one-cycle completion pulse to the winner.
- RDATA  out  8  last successfully read byte.
- ERR  out  1  high with DONE_OUT when the transaction timed out.
- BUS_START  out  1  one-cycle start pulse to the engine.
- BUS_WR  out  1  latched direction.
- BUS_ADDR  out  7  latched address.
- BUS_WDATA  out  8  latched write data.
- BUS_DONE  in  1  engine completion strobe (FRW).
- BUS_RDATA  in  8  engine read data, valid while BUS_DONE is high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RELEASE. Reset state is IDLE.
- IDLE: if REQ is nonzero, choose a winner W.
  - REQ[0] always wins.
  - Otherwise, if exactly one of REQ[2:1] is set, that requester wins.
  - If both are set, the round-robin pointer LAST decides: LAST=0 grants 1, LAST=1 grants 2.
  - Latch WR[W], ADDR slice and WDATA slice into BUS_WR/BUS_ADDR/BUS_WDATA, set GNT[W], go to ISSUE.
- ISSUE: BUS_START=1 for this cycle only. Clear the 8-bit timer and go to WAIT.
- WAIT: the timer increments every cycle.
  - If BUS_DONE=1: on a read, load RDATA from BUS_RDATA; clear the error flag; go to RELEASE.
  - Else if timer == TIMEOUT-1: set the error flag and go to RELEASE. RDATA is unchanged.
- RELEASE: DONE_OUT[W]=1 and ERR equals the error flag.
  - If W=1, set LAST=1. If W=2, set LAST=0. W=0 leaves LAST unchanged.
  - Clear GNT and go to IDLE.
- Requesters must drop REQ in the cycle after their DONE_OUT. A REQ still high on return to IDLE counts as a new request.
- A requester dropping REQ mid-transaction does not abort it; the transaction completes and DONE_OUT still pulses.
- BUS_DONE is ignored in IDLE, ISSUE and RELEASE.
- A completed write never changes RDATA. A timed-out read never changes RDATA.
- Once latched, the BUS_* address, data and direction outputs hold until the next grant. Changes to ADDR/WDATA/WR after the grant are ignored.
- An asynchronous RST assertion mid-transaction forces IDLE immediately, with no DONE_OUT. BUS_START is not re-issued.

## Timing
- All outputs are registered or Moore-decoded from state; there is no combinational path from inputs to outputs.
- Reset values: GNT=0, DONE_OUT=0, RDATA=8'h00, ERR=0, BUS_START=0, BUS_WR=0, BUS_ADDR=7'h00, BUS_WDATA=8'h00, LAST=0, timer=0.
- Sequence for a request sampled in IDLE at cycle 0:
  - cycle 1: GNT and BUS_START high (ISSUE).
  - cycle 2 onward: WAIT.
  - BUS_DONE at cycle k (k≥2): DONE_OUT and RDATA valid at cycle k+1, IDLE at k+2.
- Minimum transaction length is 4 cycles, REQ to next possible grant.
- Timeout path: DONE_OUT/ERR at cycle 2+TIMEOUT. BUS_DONE arriving in that same RELEASE cycle is ignored.
- GNT is high exactly during ISSUE, WAIT and RELEASE, and is never multi-hot.

## Test plan
- Reset, then a single read: REQ=3'b010, ADDR[13:7]=7'h21, WR=0, engine returns 8'h59 after 3 cycles → BUS_START at cycle 1, BUS_ADDR=7'h21, DONE_OUT=3'b010 at cycle 5, RDATA=8'h59, ERR=0.
- Priority: REQ=3'b111 held, each transaction acknowledged, each requester drops REQ after its DONE_OUT → grant order 0, 1, 2.
- Round-robin: REQ=3'b110 held through 4 transactions → grant order 1, 2, 1, 2; LAST toggles each RELEASE.
- Write: REQ=3'b100, WR=3'b100, ADDR[20:14]=7'h41, WDATA[23:16]=8'h30, RDATA preloaded to 8'hAA → BUS_WR=1, BUS_WDATA=8'h30, RDATA remains 8'hAA after DONE_OUT.
- Timeout: TIMEOUT=5, BUS_DONE never asserted → DONE_OUT and ERR high at cycle 7, RDATA unchanged, FSM back in IDLE at cycle 8.
- Reset mid-WAIT: pull RST low two cycles after BUS_START → GNT=0 and DONE_OUT=0 immediately. After release, BUS_START is not pulsed until a new REQ is sampled in IDLE.

Source files
------------

// File: rtl/rtc_bus_arbiter_if.sv
// Request/grant and engine-side signal bundle for the RTC bus arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/engine side.
interface rtc_bus_arbiter_if;

  logic [2:0]  REQ;
  logic [2:0]  WR;
  logic [20:0] ADDR;
  logic [23:0] WDATA;
  logic [2:0]  GNT;
  logic [2:0]  DONE_OUT;
  logic [7:0]  RDATA;
  logic        ERR;
  logic        BUS_START;
  logic        BUS_WR;
  logic [6:0]  BUS_ADDR;
  logic [7:0]  BUS_WDATA;
  logic        BUS_DONE;
  logic [7:0]  BUS_RDATA;

  modport slave (
    input  REQ,
    input  WR,
    input  ADDR,
    input  WDATA,
    input  BUS_DONE,
    input  BUS_RDATA,
    output GNT,
    output DONE_OUT,
    output RDATA,
    output ERR,
    output BUS_START,
    output BUS_WR,
    output BUS_ADDR,
    output BUS_WDATA
  );

  modport master (
    output REQ,
    output WR,
    output ADDR,
    output WDATA,
    output BUS_DONE,
    output BUS_RDATA,
    input  GNT,
    input  DONE_OUT,
    input  RDATA,
    input  ERR,
    input  BUS_START,
    input  BUS_WR,
    input  BUS_ADDR,
    input  BUS_WDATA
  );

endinterface

// File: rtl/rtc_bus_arbiter.sv
// Arbitrates three requesters onto the single RTC transaction engine.
// Requester 0 has fixed priority, and requesters 1/2 share a round-robin slot. Every output is a register.
module rtc_bus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic                 CLK,
  input  logic                 RST,
  rtc_bus_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [2:0]  gnt_r;
  logic [2:0]  gnt_s;
  logic        last_r;
  logic        last_s;
  logic [7:0]  timer_r;
  logic [7:0]  timer_s;
  logic [7:0]  rdata_r;
  logic [7:0]  rdata_s;
  logic        err_r;
  logic        err_s;
  logic        bus_start_r;
  logic        bus_start_s;
  logic [2:0]  done_r;
  logic [2:0]  done_s;
  logic        bus_wr_r;
  logic        bus_wr_s;
  logic [6:0]  bus_addr_r;
  logic [6:0]  bus_addr_s;
  logic [7:0]  bus_wdata_r;
  logic [7:0]  bus_wdata_s;
  logic [1:0]  win_s;

  // Requester 0 always wins; a 1/2 tie goes to whoever was not served last.
  function automatic logic [1:0] pick_winner(input logic [2:0] req, input logic last);
    logic [1:0] w;
    if (req[0]) begin
      w = 2'd0;
    end else if (req[1] && req[2]) begin
      if (last) begin
        w = 2'd2;
      end else begin
        w = 2'd1;
      end
    end else if (req[1]) begin
      w = 2'd1;
    end else begin
      w = 2'd2;
    end
    return w;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // State and output register bank.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      gnt_r       <= 3'b000;
      last_r      <= 1'b0;
      timer_r     <= 8'd0;
      rdata_r     <= 8'h00;
      err_r       <= 1'b0;
      bus_start_r <= 1'b0;
      done_r      <= 3'b000;
      bus_wr_r    <= 1'b0;
      bus_addr_r  <= 7'h00;
      bus_wdata_r <= 8'h00;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      last_r      <= last_s;
      timer_r     <= timer_s;
      rdata_r     <= rdata_s;
      err_r       <= err_s;
      bus_start_r <= bus_start_s;
      done_r      <= done_s;
      bus_wr_r    <= bus_wr_s;
      bus_addr_r  <= bus_addr_s;
      bus_wdata_r <= bus_wdata_s;
    end
  end

  // Next-state logic. The start, done and error pulses default low so that each lasts one cycle.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    last_s      = last_r;
    timer_s     = timer_r;
    rdata_s     = rdata_r;
    err_s       = 1'b0;
    bus_start_s = 1'b0;
    done_s      = 3'b000;
    bus_wr_s    = bus_wr_r;
    bus_addr_s  = bus_addr_r;
    bus_wdata_s = bus_wdata_r;
    win_s       = pick_winner(bus.REQ, last_r);

    case (state_r)
      IDLE: begin
        if (bus.REQ != 3'b000) begin
          gnt_s       = onehot3(win_s);
          bus_start_s = 1'b1;
          state_s     = ISSUE;
          case (win_s)
            2'd0: begin
              bus_wr_s    = bus.WR[0];
              bus_addr_s  = bus.ADDR[6:0];
              bus_wdata_s = bus.WDATA[7:0];
            end
            2'd1: begin
              bus_wr_s    = bus.WR[1];
              bus_addr_s  = bus.ADDR[13:7];
              bus_wdata_s = bus.WDATA[15:8];
            end
            2'd2: begin
              bus_wr_s    = bus.WR[2];
              bus_addr_s  = bus.ADDR[20:14];
              bus_wdata_s = bus.WDATA[23:16];
            end
            default: begin
              bus_wr_s    = bus_wr_r;
              bus_addr_s  = bus_addr_r;
              bus_wdata_s = bus_wdata_r;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        timer_s = 8'd0;
        state_s = WAIT;
      end
      WAIT: begin
        timer_s = timer_r + 8'd1;
        if (bus.BUS_DONE) begin
          if (!bus_wr_r) begin
            rdata_s = bus.BUS_RDATA;
          end else begin
            rdata_s = rdata_r;
          end
          err_s   = 1'b0;
          done_s  = gnt_r;
          state_s = RELEASE;
        end else if (timer_r == (TIMEOUT - 8'd1)) begin
          // Timed out: report the error and leave RDATA untouched.
          err_s   = 1'b1;
          done_s  = gnt_r;
          state_s = RELEASE;
        end else begin
          state_s = WAIT;
        end
      end
      RELEASE: begin
        gnt_s   = 3'b000;
        state_s = IDLE;
        if (gnt_r[1]) begin
          last_s = 1'b1;
        end else if (gnt_r[2]) begin
          last_s = 1'b0;
        end else begin
          last_s = last_r;
        end
      end
      default: begin
        gnt_s   = 3'b000;
        state_s = IDLE;
      end
    endcase
  end

  assign bus.GNT       = gnt_r;
  assign bus.DONE_OUT  = done_r;
  assign bus.RDATA     = rdata_r;
  assign bus.ERR       = err_r;
  assign bus.BUS_START = bus_start_r;
  assign bus.BUS_WR    = bus_wr_r;
  assign bus.BUS_ADDR  = bus_addr_r;
  assign bus.BUS_WDATA = bus_wdata_r;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed testbench for rtc_bus_arbiter, built with TIMEOUT=5 so that the timeout path is short.
module tb_rtc_bus_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  rtc_bus_arbiter_if bus();

  rtc_bus_arbiter #(.TIMEOUT(8'd5)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.REQ = 3'b000; bus.WR = 3'b000; bus.ADDR = 21'h0; bus.WDATA = 24'h0;
    bus.BUS_DONE = 1'b0; bus.BUS_RDATA = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Called at cycle 0 with REQ already driven. Engine answers at cycle 3; returns at cycle 4 (RELEASE).
  task automatic engine_cycle(input logic [7:0] rd, output logic [2:0] gnt_seen,
                              output logic [2:0] done_seen, output logic err_seen);
    tick();
    gnt_seen = bus.GNT;
    tick();
    tick();
    bus.BUS_DONE = 1'b1; bus.BUS_RDATA = rd;
    tick();
    bus.BUS_DONE = 1'b0;
    done_seen = bus.DONE_OUT;
    err_seen  = bus.ERR;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.REQ = 3'b111; bus.WR = 3'b111; bus.ADDR = 21'h1FFFFF; bus.WDATA = 24'hFFFFFF;
    bus.BUS_DONE = 1'b1; bus.BUS_RDATA = 8'hFF;
    tick();
    tick();
    vectors++; if (bus.GNT !== 3'b000) begin miscompares++; $display("FAIL reset_gnt: got %b expected 000", bus.GNT); end
    vectors++; if (bus.DONE_OUT !== 3'b000) begin miscompares++; $display("FAIL reset_done: got %b expected 000", bus.DONE_OUT); end
    vectors++; if (bus.RDATA !== 8'h00) begin miscompares++; $display("FAIL reset_rdata: got %h expected 00", bus.RDATA); end
    vectors++; if (bus.ERR !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", bus.ERR); end
    vectors++; if (bus.BUS_START !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b expected 0", bus.BUS_START); end
    vectors++; if (bus.BUS_WR !== 1'b0) begin miscompares++; $display("FAIL reset_bus_wr: got %b expected 0", bus.BUS_WR); end
    vectors++; if (bus.BUS_ADDR !== 7'h00) begin miscompares++; $display("FAIL reset_bus_addr: got %h expected 00", bus.BUS_ADDR); end
    vectors++; if (bus.BUS_WDATA !== 8'h00) begin miscompares++; $display("FAIL reset_bus_wdata: got %h expected 00", bus.BUS_WDATA); end
  endtask

  task automatic test_single_read();
    apply_reset();
    bus.REQ = 3'b010; bus.WR = 3'b000; bus.ADDR = {7'h00, 7'h21, 7'h00};
    tick();
    vectors++; if (bus.BUS_START !== 1'b1) begin miscompares++; $display("FAIL rd_start_c1: got %b expected 1", bus.BUS_START); end
    vectors++; if (bus.GNT !== 3'b010) begin miscompares++; $display("FAIL rd_gnt_c1: got %b expected 010", bus.GNT); end
    vectors++; if (bus.BUS_ADDR !== 7'h21) begin miscompares++; $display("FAIL rd_bus_addr: got %h expected 21", bus.BUS_ADDR); end
    vectors++; if (bus.BUS_WR !== 1'b0) begin miscompares++; $display("FAIL rd_bus_wr: got %b expected 0", bus.BUS_WR); end
    tick();
    vectors++; if (bus.BUS_START !== 1'b0) begin miscompares++; $display("FAIL rd_start_c2: got %b expected 0", bus.BUS_START); end
    tick();
    tick();
    bus.BUS_DONE = 1'b1; bus.BUS_RDATA = 8'h59;
    vectors++; if (bus.DONE_OUT !== 3'b000) begin miscompares++; $display("FAIL rd_done_c4: got %b expected 000", bus.DONE_OUT); end
    tick();
    bus.BUS_DONE = 1'b0; bus.BUS_RDATA = 8'h00;
    vectors++; if (bus.DONE_OUT !== 3'b010) begin miscompares++; $display("FAIL rd_done_c5: got %b expected 010", bus.DONE_OUT); end
    vectors++; if (bus.RDATA !== 8'h59) begin miscompares++; $display("FAIL rd_rdata: got %h expected 59", bus.RDATA); end
    vectors++; if (bus.ERR !== 1'b0) begin miscompares++; $display("FAIL rd_err: got %b expected 0", bus.ERR); end
    bus.REQ = 3'b000;
    tick();
    vectors++; if (bus.GNT !== 3'b000) begin miscompares++; $display("FAIL rd_gnt_c6: got %b expected 000", bus.GNT); end
    vectors++; if (bus.DONE_OUT !== 3'b000) begin miscompares++; $display("FAIL rd_done_c6: got %b expected 000", bus.DONE_OUT); end
  endtask

  task automatic test_priority();
    logic [2:0] g;
    logic [2:0] d;
    logic       e;
    logic [2:0] exp_g [3];
    logic [2:0] next_req [3];
    exp_g    = '{3'b001, 3'b010, 3'b100};
    next_req = '{3'b110, 3'b100, 3'b000};
    apply_reset();
    bus.REQ = 3'b111;
    for (int i = 0; i < 3; i++) begin
      engine_cycle(8'h10, g, d, e);
      vectors++; if (g !== exp_g[i]) begin miscompares++; $display("FAIL prio_gnt_%0d: got %b expected %b", i, g, exp_g[i]); end
      vectors++; if (d !== exp_g[i]) begin miscompares++; $display("FAIL prio_done_%0d: got %b expected %b", i, d, exp_g[i]); end
      bus.REQ = next_req[i];
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] g;
    logic [2:0] d;
    logic       e;
    logic [2:0] exp_g [4];
    exp_g = '{3'b010, 3'b100, 3'b010, 3'b100};
    apply_reset();
    bus.REQ = 3'b110;
    for (int i = 0; i < 4; i++) begin
      engine_cycle(8'h20, g, d, e);
      vectors++; if (g !== exp_g[i]) begin miscompares++; $display("FAIL rr_gnt_%0d: got %b expected %b", i, g, exp_g[i]); end
      tick();
    end
    bus.REQ = 3'b000;
    tick();
  endtask

  task automatic test_write();
    logic [2:0] g;
    logic [2:0] d;
    logic       e;
    apply_reset();
    bus.REQ = 3'b010; bus.WR = 3'b000;
    engine_cycle(8'hAA, g, d, e);
    bus.REQ = 3'b000;
    tick();
    bus.REQ = 3'b100; bus.WR = 3'b100;
    bus.ADDR = {7'h41, 7'h00, 7'h00}; bus.WDATA = {8'h30, 16'h0000};
    engine_cycle(8'h5C, g, d, e);
    vectors++; if (d !== 3'b100) begin miscompares++; $display("FAIL wr_done: got %b expected 100", d); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL wr_err: got %b expected 0", e); end
    vectors++; if (bus.BUS_WR !== 1'b1) begin miscompares++; $display("FAIL wr_bus_wr: got %b expected 1", bus.BUS_WR); end
    vectors++; if (bus.BUS_ADDR !== 7'h41) begin miscompares++; $display("FAIL wr_bus_addr: got %h expected 41", bus.BUS_ADDR); end
    vectors++; if (bus.BUS_WDATA !== 8'h30) begin miscompares++; $display("FAIL wr_bus_wdata: got %h expected 30", bus.BUS_WDATA); end
    vectors++; if (bus.RDATA !== 8'hAA) begin miscompares++; $display("FAIL wr_rdata: got %h expected AA", bus.RDATA); end
    bus.REQ = 3'b000; bus.WR = 3'b000; bus.ADDR = 21'h1FFFFF; bus.WDATA = 24'hFFFFFF;
    tick();
    tick();
    vectors++; if (bus.BUS_ADDR !== 7'h41) begin miscompares++; $display("FAIL wr_addr_hold: got %h expected 41", bus.BUS_ADDR); end
    vectors++; if (bus.BUS_WDATA !== 8'h30) begin miscompares++; $display("FAIL wr_wdata_hold: got %h expected 30", bus.BUS_WDATA); end
  endtask

  task automatic test_timeout();
    logic [2:0] g;
    logic [2:0] d;
    logic       e;
    int         found_c;
    apply_reset();
    bus.REQ = 3'b001; bus.WR = 3'b000;
    engine_cycle(8'h3C, g, d, e);
    bus.REQ = 3'b000;
    tick();
    bus.REQ = 3'b001;
    found_c = 0;
    for (int c = 1; c <= 20 && found_c == 0; c++) begin
      tick();
      if (bus.DONE_OUT != 3'b000) found_c = c;
    end
    vectors++; if (found_c !== 7) begin miscompares++; $display("FAIL to_cycle: got %0d expected 7", found_c); end
    vectors++; if (bus.DONE_OUT !== 3'b001) begin miscompares++; $display("FAIL to_done: got %b expected 001", bus.DONE_OUT); end
    vectors++; if (bus.ERR !== 1'b1) begin miscompares++; $display("FAIL to_err: got %b expected 1", bus.ERR); end
    vectors++; if (bus.RDATA !== 8'h3C) begin miscompares++; $display("FAIL to_rdata: got %h expected 3C", bus.RDATA); end
    bus.REQ = 3'b000; bus.BUS_DONE = 1'b1; bus.BUS_RDATA = 8'h77;
    tick();
    vectors++; if (bus.GNT !== 3'b000) begin miscompares++; $display("FAIL to_gnt_c8: got %b expected 000", bus.GNT); end
    vectors++; if (bus.ERR !== 1'b0) begin miscompares++; $display("FAIL to_err_c8: got %b expected 0", bus.ERR); end
    vectors++; if (bus.RDATA !== 8'h3C) begin miscompares++; $display("FAIL to_late_done: got %h expected 3C", bus.RDATA); end
    bus.BUS_DONE = 1'b0;
    tick();
    vectors++; if (bus.BUS_START !== 1'b0) begin miscompares++; $display("FAIL to_idle_start: got %b expected 0", bus.BUS_START); end
  endtask

  task automatic test_reset_mid_wait();
    int starts;
    apply_reset();
    bus.REQ = 3'b010; bus.WR = 3'b000;
    tick();
    vectors++; if (bus.BUS_START !== 1'b1) begin miscompares++; $display("FAIL rm_start: got %b expected 1", bus.BUS_START); end
    tick();
    tick();
    rst_n = 1'b0; bus.REQ = 3'b000;
    #1;
    vectors++; if (bus.GNT !== 3'b000) begin miscompares++; $display("FAIL rm_gnt: got %b expected 000", bus.GNT); end
    vectors++; if (bus.DONE_OUT !== 3'b000) begin miscompares++; $display("FAIL rm_done: got %b expected 000", bus.DONE_OUT); end
    tick();
    rst_n = 1'b1;
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.BUS_START !== 1'b0 || bus.DONE_OUT !== 3'b000) starts++;
    end
    vectors++; if (starts !== 0) begin miscompares++; $display("FAIL rm_no_restart: got %0d expected 0", starts); end
    bus.REQ = 3'b001;
    tick();
    vectors++; if (bus.BUS_START !== 1'b1) begin miscompares++; $display("FAIL rm_new_start: got %b expected 1", bus.BUS_START); end
    vectors++; if (bus.GNT !== 3'b001) begin miscompares++; $display("FAIL rm_new_gnt: got %b expected 001", bus.GNT); end
    // BUS_DONE is raised during ISSUE; only the WAIT-cycle sample counts, so DONE_OUT appears at cycle 3.
    bus.REQ = 3'b000; bus.BUS_DONE = 1'b1; bus.BUS_RDATA = 8'h44;
    tick();
    tick();
    bus.BUS_DONE = 1'b0;
    vectors++; if (bus.DONE_OUT !== 3'b001) begin miscompares++; $display("FAIL rm_issue_ignore: got %b expected 001", bus.DONE_OUT); end
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_write();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
